// File: rtl/capture_controller.sv
// capture_controller: fills sample memory from the sampler on 'S', streams it out through the UART on 'D', stops on 'A'.
module capture_controller #(
  parameter int ADDR_WIDTH = 16,
  parameter logic [7:0] CMD_CAPTURE = 8'h53,
  parameter logic [7:0] CMD_DUMP = 8'h44,
  parameter logic [7:0] CMD_ABORT = 8'h41
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iRx_Done,
  input  logic [7:0]            iRx_Data,
  input  logic                  iSample_Valid,
  input  logic [7:0]            iSample_Data,
  output logic [ADDR_WIDTH-1:0] oMem_Addr,
  output logic [7:0]            oMem_Wdata,
  output logic                  oMem_We,
  input  logic [7:0]            iMem_Rdata,
  output logic                  oTx_Start,
  output logic [7:0]            oTx_Data,
  input  logic                  iTx_Done,
  output logic                  oBusy,
  output logic                  oCapture_Done,
  output logic                  oDump_Done
);
  typedef enum logic [2:0] {IDLE, CAPTURE, RD_ADDR, RD_LATCH, TX_START, TX_WAIT} state_t;
  state_t state;
  logic last, abort;
  assign last = &oMem_Addr;
  assign abort = iRx_Done && iRx_Data == CMD_ABORT && state != IDLE;
  assign oMem_Wdata = iSample_Data;
  // the abort-cycle sample is still written; only the next state is affected
  assign oMem_We = state == CAPTURE && iSample_Valid;
  assign oTx_Start = state == TX_START;
  assign oBusy = state != IDLE;
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state <= IDLE;
      oMem_Addr <= '0;
      oTx_Data <= '0;
      oCapture_Done <= 1'b0;
      oDump_Done <= 1'b0;
    end else begin
      oCapture_Done <= 1'b0;
      oDump_Done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        oMem_Addr <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (iRx_Done && iRx_Data == CMD_CAPTURE) begin
              oMem_Addr <= '0;
              state <= CAPTURE;
            end else if (iRx_Done && iRx_Data == CMD_DUMP) begin
              oMem_Addr <= '0;
              state <= RD_ADDR;
            end
          end
          CAPTURE: begin
            if (iSample_Valid) begin
              oMem_Addr <= oMem_Addr + ADDR_WIDTH'(1);
              oCapture_Done <= last;
              state <= last ? IDLE : CAPTURE;
            end
          end
          RD_ADDR: state <= RD_LATCH;
          RD_LATCH: begin
            oTx_Data <= iMem_Rdata;
            state <= TX_START;
          end
          TX_START: state <= TX_WAIT;
          TX_WAIT: begin
            if (iTx_Done) begin
              oMem_Addr <= oMem_Addr + ADDR_WIDTH'(1);
              oDump_Done <= last;
              state <= last ? IDLE : RD_ADDR;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_capture_controller.sv
// tb_capture_controller: scoreboard bench with memory and transmitter models around capture_controller.
module tb_capture_controller;
  localparam int AW = 4;
  logic clk = 0, rst = 1;
  logic rx_done = 0, sample_valid = 0, tx_force = 0, tx_auto = 0, tx_en = 1;
  logic [7:0] rx_data = 0, sample_data = 0, mem_rdata, mem_wdata, tx_data;
  logic [AW-1:0] mem_addr;
  logic mem_we, tx_start, tx_done, busy, capture_done, dump_done;
  logic [7:0] mem [16];
  logic [11:0] wr_q [$];
  logic [7:0] tx_q [$];
  int compared = 0, mismatched = 0, starts = 0, cap_cnt = 0, dump_cnt = 0, tx_cnt = 0;
  int s0, d0;

  assign tx_done = tx_auto | tx_force;
  always #5 clk = ~clk;

  capture_controller #(.ADDR_WIDTH(AW)) dut (
    .iClock(clk), .iReset(rst), .iRx_Done(rx_done), .iRx_Data(rx_data),
    .iSample_Valid(sample_valid), .iSample_Data(sample_data),
    .oMem_Addr(mem_addr), .oMem_Wdata(mem_wdata), .oMem_We(mem_we), .iMem_Rdata(mem_rdata),
    .oTx_Start(tx_start), .oTx_Data(tx_data), .iTx_Done(tx_done),
    .oBusy(busy), .oCapture_Done(capture_done), .oDump_Done(dump_done)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // transmitter model: iTx_Done arrives 10 cycles after each start
  always @(posedge clk) begin
    tx_auto <= 1'b0;
    if (tx_start) tx_cnt <= 10;
    else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_auto <= tx_en;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (mem_we) begin
      if (wr_q.size() == 0) check("unexpected_we", mem_we, 0);
      else begin
        logic [11:0] e;
        e = wr_q.pop_front();
        check("wr_addr", mem_addr, e[11:8]);
        check("wr_data", mem_wdata, e[7:0]);
      end
    end
    if (tx_start) begin
      starts++;
      if (tx_q.size() == 0) check("unexpected_tx_start", tx_start, 0);
      else check("tx_data", tx_data, tx_q.pop_front());
    end
    if (capture_done) cap_cnt++;
    if (dump_done) dump_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_done = 1;
    rx_data = b;
    tick();
    rx_done = 0;
  endtask

  task automatic wait_starts(input int target, input string name);
    for (int k = 0; k < 400 && starts < target; k++) tick();
    check(name, starts, target);
  endtask

  task automatic wait_dump(input int target);
    for (int k = 0; k < 600 && dump_cnt < target; k++) tick();
    check("dump_done_wait", dump_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    rst = 0;
    repeat (20) tick();
    check("rst_busy", busy, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_strobes", {mem_we, tx_start, capture_done, dump_done}, 0);
    send(8'h53);
    for (int i = 0; i < 16; i++) begin
      sample_valid = 1;
      sample_data = 8'hA0 + 8'(i);
      wr_q.push_back({4'(i), 8'hA0 + 8'(i)});
      rx_done = (i == 3 || i == 7 || i == 11);
      rx_data = i == 3 ? 8'h00 : i == 7 ? 8'h44 : 8'h53;
      tick();
    end
    rx_done = 0;
    check("cap_done_pulse", capture_done, 1);
    check("cap_busy", busy, 0);
    check("cap_addr_wrap", mem_addr, 0);
    sample_data = 8'hFF;
    repeat (4) tick();
    sample_valid = 0;
    check("cap_done_once", cap_cnt, 1);
    check("cap_queue_empty", wr_q.size(), 0);
    send(8'h58);
    check("idle_ignore_busy", busy, 0);
    s0 = starts;
    for (int i = 0; i < 16; i++) tx_q.push_back(8'hA0 + 8'(i));
    send(8'h44);
    check("dump_busy", busy, 1);
    wait_dump(1);
    check("dump_starts", starts - s0, 16);
    check("dump_queue_empty", tx_q.size(), 0);
    check("dump_idle", busy, 0);
    check("dump_addr", mem_addr, 0);
    s0 = starts;
    for (int i = 0; i < 5; i++) tx_q.push_back(8'hA0 + 8'(i));
    send(8'h44);
    wait_starts(s0 + 5, "abort_wait_5th");
    send(8'h41);
    check("abort_busy", busy, 0);
    check("abort_addr", mem_addr, 0);
    repeat (30) tick();
    check("abort_no_more_tx", starts - s0, 5);
    check("abort_no_dump_done", dump_cnt, 1);
    for (int i = 0; i < 16; i++) tx_q.push_back(8'hA0 + 8'(i));
    send(8'h44);
    wait_dump(2);
    check("redump_queue_empty", tx_q.size(), 0);
    s0 = starts;
    tx_q.push_back(8'hA0);
    send(8'h44);
    wait_starts(s0 + 1, "rst_wait_start");
    rst = 1;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_addr", mem_addr, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_strobes", {mem_we, tx_start, capture_done, dump_done}, 0);
    rst = 0;
    repeat (15) tick();
    check("midrst_idle", busy, 0);
    tx_en = 0;
    s0 = starts;
    d0 = dump_cnt;
    tx_q.push_back(8'hA0);
    send(8'h44);
    wait_starts(s0 + 1, "race_wait_start");
    rx_done = 1;
    rx_data = 8'h41;
    tx_force = 1;
    tick();
    rx_done = 0;
    tx_force = 0;
    check("race_busy", busy, 0);
    check("race_addr", mem_addr, 0);
    repeat (5) tick();
    check("race_no_dump_done", dump_cnt, d0);
    check("race_no_tx", starts - s0, 1);
    send(8'h53);
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1;
      sample_data = 8'h50 + 8'(i);
      wr_q.push_back({4'(i), 8'h50 + 8'(i)});
      rx_done = i == 3;
      rx_data = 8'h41;
      tick();
    end
    sample_valid = 0;
    rx_done = 0;
    check("cap_abort_busy", busy, 0);
    check("cap_abort_addr", mem_addr, 0);
    repeat (3) tick();
    check("cap_abort_writes", wr_q.size(), 0);
    check("cap_abort_no_done", cap_cnt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/capture_controller.md
# capture_controller

Top-level sequencer for the RS-232 capture path. It decodes command bytes from the UART receiver and fills the sample memory with bytes from the sampler. It then streams the whole memory out through the UART transmitter. It owns the memory address, write-enable and transmitter start lines, so the sampler and sender never drive the memory at the same time.

## Interface
- ADDR_WIDTH, 16, sample-memory address width; depth = 2^ADDR_WIDTH bytes
- CMD_CAPTURE, 8'h53 ('S'), command byte that starts a capture
- CMD_DUMP, 8'h44 ('D'), command byte that starts a dump
- CMD_ABORT, 8'h41 ('A'), command byte that aborts capture or dump

- iClock  in  1  single system clock; everything is on its rising edge
- iReset  in  1  synchronous, active-high reset
- iRx_Done  in  1  one-cycle pulse: iRx_Data holds a received byte
- iRx_Data  in  8  received byte
- iSample_Valid  in  1  sampler presents a byte this cycle
- iSample_Data  in  8  sample byte
- oMem_Addr  out  ADDR_WIDTH  memory address (registered counter)
- oMem_Wdata  out  8  memory write data (= iSample_Data, combinational)
- oMem_We  out  1  write strobe (combinational)
- iMem_Rdata  in  8  read data, valid one cycle after oMem_Addr is presented
- oTx_Start  out  1  one-cycle pulse: transmitter sends oTx_Data
- oTx_Data  out  8  byte to transmit (registered)
- iTx_Done  in  1  one-cycle pulse: transmitter finished a byte
- oBusy  out  1  high whenever the state is not IDLE
- oCapture_Done  out  1  one-cycle pulse: capture filled the memory
- oDump_Done  out  1  one-cycle pulse: last byte transmitted

## Operation
- States: IDLE, CAPTURE, RD_ADDR, RD_LATCH, TX_START, TX_WAIT.
- Reset: state IDLE; oMem_Addr 0; oTx_Data 0; all strobes, pulses and oBusy 0.
- IDLE:
  - iRx_Done with CMD_CAPTURE: addr ← 0, go to CAPTURE.
  - iRx_Done with CMD_DUMP: addr ← 0, go to RD_ADDR.
  - Any other byte is ignored.
- CAPTURE:
  - oMem_We = iSample_Valid.
  - On each valid sample the byte is written at oMem_Addr, then addr increments.
  - The write at addr = 2^ADDR_WIDTH−1 is the last one. It pulses oCapture_Done next cycle, leaves addr at 0 (wrap) and returns to IDLE.
  - Every address, including the last, is written exactly once.
- Dump:
  - RD_ADDR: present addr; go to RD_LATCH.
  - RD_LATCH: oTx_Data ← iMem_Rdata; go to TX_START.
  - TX_START: oTx_Start = 1 for exactly one cycle; go to TX_WAIT.
  - TX_WAIT: hold until iTx_Done.
    - If addr = 2^ADDR_WIDTH−1: pulse oDump_Done, addr ← 0, go to IDLE.
    - Otherwise addr increments and the state goes to RD_ADDR.
  - Every address, including the last, is transmitted exactly once, in ascending order.
- Abort: iRx_Done with CMD_ABORT in any non-IDLE state → IDLE next cycle and addr ← 0.
  - No done pulse.
  - No further oMem_We or oTx_Start.
  - A transmission already in flight completes on its own; its iTx_Done is ignored in IDLE.
- CMD_CAPTURE or CMD_DUMP received while not IDLE: ignored.
- oMem_We is 0 in every state except CAPTURE. Memory contents are never written during a dump.
- iTx_Done outside TX_WAIT: ignored.
- iSample_Valid outside CAPTURE: ignored.

## Timing
- Command latency: iRx_Done at cycle N → state change at edge N+1; first write possible in cycle N+1.
- Capture throughput: one byte per cycle while iSample_Valid is held high. Full capture takes ≥ 2^ADDR_WIDTH cycles.
- Dump per byte:
  - oTx_Start is asserted 2 cycles after entering RD_ADDR.
  - The next RD_ADDR starts the cycle after iTx_Done.
  - Overhead is 3 cycles per byte plus transmitter time.
- oTx_Data is stable from the cycle of oTx_Start until the next RD_LATCH.
- Simultaneous CMD_ABORT and iTx_Done in TX_WAIT: abort wins, with no oDump_Done and no address increment.
- Simultaneous CMD_ABORT and iSample_Valid in CAPTURE: that write still occurs (combinational); then IDLE.
- iReset asserted mid-operation: reset values at the next edge, regardless of state or pending pulses.

## Test plan
- Reset with ADDR_WIDTH=4, then 20 idle cycles -> all outputs 0, oBusy 0, no strobes.
- 'S', then iSample_Valid high for 16 cycles with data 8'hA0..8'hAF -> writes at addresses 0..15 with matching data; oCapture_Done one cycle after the 16th write; oBusy 0; further samples cause no writes.
- After the capture above, 'D' with a transmitter model returning iTx_Done 10 cycles after each oTx_Start -> exactly 16 oTx_Start pulses carrying 8'hA0..8'hAF in order; oDump_Done once; state IDLE.
- During the dump, 'A' after the 5th oTx_Start -> no further oTx_Start; no oDump_Done; oMem_Addr 0; a following 'D' restarts from address 0 with byte 8'hA0.
- Bytes 8'h00, 8'h44 and 8'h53 injected during CAPTURE -> ignored, capture continues; byte 8'h58 in IDLE -> no state change.
- iReset pulsed during TX_WAIT, with iTx_Done and 'A' arriving in the same cycle in a separate run -> reset values next cycle; the abort case gives IDLE with no oDump_Done.
